as_master_bpi: RTL

AS_MASTER_BPI -- requirements
Module: as_master_bpi

---
 rtl/as_pack.sv | 17 +
 rtl/as_master_bpi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/as_pack.sv
// as_pack -- shared types and default widths for the as_master_bpi Wishbone master.
//   reg_width   : default data width
//   daddr_width : default address width
//   wbdSel      : default byte-select width (reg_width/8)
//   state_e     : master FSM state encoding
package as_pack;

  localparam int reg_width   = 64;
  localparam int daddr_width = 64;
  localparam int wbdSel      = reg_width / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

endpackage

// File: rtl/as_master_bpi.sv
// as_master_bpi -- single-transfer Wishbone master driven by a simple core
// read/write request interface.
//
// Ports
//   clk_i, rst_i              : clock, synchronous active-high reset
//   rd_i, wr_i                : core read / write request (both high => write)
//   addr_i, wdat_i, sel_i     : core address, write data, byte selects
//   rdat_o                    : read data (updated on read completion only)
//   busy_o                    : transfer in progress
//   done_o                    : one-cycle completion pulse
//   err_o                     : completion was a timeout (qualified by done_o)
//   wbAdr_o..wbCyc_o          : registered Wishbone master outputs
//   wbDat_i, wbAck_i          : Wishbone slave read data and acknowledge
//
// Build option
//   AS_MBPI_TIMEOUT_EN : when defined, a transfer with no ack for TIMEOUT bus
//                        cycles is terminated with done_o=1, err_o=1, rdat_o=0.
//                        When undefined the bus waits for ack indefinitely.
module as_master_bpi
  import as_pack::*;
#(
  parameter int ADDR_W  = daddr_width,
  parameter int DATA_W  = reg_width,
  parameter int SEL_W   = wbdSel,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdat_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [DATA_W-1:0] rdat_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] wbAdr_o,
  output logic [DATA_W-1:0] wbDat_o,
  output logic [SEL_W-1:0]  wbSel_o,
  output logic              wbWe_o,
  output logic              wbStb_o,
  output logic              wbCyc_o,
  input  logic [DATA_W-1:0] wbDat_i,
  input  logic              wbAck_i
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("as_master_bpi: TIMEOUT must be at least 1");
  end

  state_e            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              done_q, done_d;

`ifdef AS_MBPI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // cnt_q holds the number of bus cycles already spent before the current one,
  // so the TIMEOUT-th bus cycle is the one where cnt_q == TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    done_d  = 1'b0;
`ifdef AS_MBPI_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // wr_i wins when both requests are high.
        if (rd_i | wr_i) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = wr_i;
          adr_d   = addr_i;
          dat_d   = wdat_i;
          sel_d   = sel_i;
`ifdef AS_MBPI_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (wbAck_i) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          if (!we_q) rdat_d = wbDat_i;
        end
`ifdef AS_MBPI_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdat_d  = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdat_q  <= '0;
      done_q  <= 1'b0;
`ifdef AS_MBPI_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
`ifdef AS_MBPI_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // cyc is high exactly while in BUS, so it doubles as stb and busy.
  assign wbCyc_o = cyc_q;
  assign wbStb_o = cyc_q;
  assign busy_o  = cyc_q;
  assign wbWe_o  = we_q;
  assign wbAdr_o = adr_q;
  assign wbDat_o = dat_q;
  assign wbSel_o = sel_q;
  assign rdat_o  = rdat_q;
  assign done_o  = done_q;
`ifdef AS_MBPI_TIMEOUT_EN
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule
